// File: rtl/osd_video_mixer.sv
// Video-side companion to the OSD generator: derives active-area coordinates,
// delays the pixel stream by the generator latency, and mixes the OSD overlay in.
module osd_video_mixer #(
  parameter int OSD_LATENCY = 6,
  parameter int COLOR_W     = 8
) (
  input  logic               vclk,
  input  logic               rst_n,
  input  logic [COLOR_W-1:0] R_i,
  input  logic [COLOR_W-1:0] G_i,
  input  logic [COLOR_W-1:0] B_i,
  input  logic               HSYNC_i,
  input  logic               VSYNC_i,
  input  logic               DE_i,
  input  logic               blend_en,
  input  logic               osd_enable,
  input  logic               osd_color,
  output logic [10:0]        xpos,
  output logic [10:0]        ypos,
  output logic [COLOR_W-1:0] R_o,
  output logic [COLOR_W-1:0] G_o,
  output logic [COLOR_W-1:0] B_o,
  output logic               HSYNC_o,
  output logic               VSYNC_o,
  output logic               DE_o
);

  // Packed pixel word: {R, G, B, HSYNC, VSYNC, DE}
  localparam int PW = 3 * COLOR_W + 3;
  localparam logic [PW-1:0] IDLE_WORD = {{(3 * COLOR_W){1'b0}}, 3'b110};
  localparam logic [10:0]   COORD_MAX = 11'h7FF;

  logic [PW-1:0]      dly_reg [0:OSD_LATENCY];
  logic               blend_reg;
  logic               s0_de;
  logic               s0_vs;
  logic               vsync_fall;
  logic [PW-1:0]      tail;
  logic [COLOR_W-1:0] tail_r, tail_g, tail_b;
  logic               tail_hs, tail_vs, tail_de;
  logic [COLOR_W-1:0] r_next, g_next, b_next;

  assign s0_de      = dly_reg[0][0];
  assign s0_vs      = dly_reg[0][1];
  assign vsync_fall = !VSYNC_i && s0_vs;

  // Stage 0 plus OSD_LATENCY further stages; the last one lines up with osd_enable/osd_color
  always_ff @(posedge vclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= OSD_LATENCY; i++) dly_reg[i] <= IDLE_WORD;
    end else begin
      dly_reg[0] <= {R_i, G_i, B_i, HSYNC_i, VSYNC_i, DE_i};
      for (int i = 1; i <= OSD_LATENCY; i++) dly_reg[i] <= dly_reg[i-1];
    end
  end

  always_ff @(posedge vclk or negedge rst_n) begin
    if (!rst_n) begin
      xpos      <= '0;
      ypos      <= '0;
      blend_reg <= 1'b0;
    end else begin
      if (DE_i) begin
        if (!s0_de)                 xpos <= '0;
        else if (xpos != COORD_MAX) xpos <= xpos + 11'd1;
      end
      // Vsync assertion wins over an end-of-line on the same edge
      if (vsync_fall) begin
        ypos      <= '0;
        blend_reg <= blend_en;
      end else if (s0_de && !DE_i && ypos != COORD_MAX) begin
        ypos <= ypos + 11'd1;
      end
    end
  end

  assign tail = dly_reg[OSD_LATENCY];
  assign {tail_r, tail_g, tail_b, tail_hs, tail_vs, tail_de} = tail;

  always_comb begin
    r_next = tail_r;
    g_next = tail_g;
    b_next = tail_b;
    if (osd_enable && tail_de) begin
      if (osd_color) begin
        r_next = '1;
        g_next = '1;
        b_next = '1;
      end else if (blend_reg) begin
        r_next = tail_r >> 2;
        g_next = tail_g >> 2;
        b_next = tail_b >> 2;
      end else begin
        r_next = '0;
        g_next = '0;
        b_next = '0;
      end
    end
  end

  always_ff @(posedge vclk or negedge rst_n) begin
    if (!rst_n) begin
      R_o     <= '0;
      G_o     <= '0;
      B_o     <= '0;
      HSYNC_o <= 1'b1;
      VSYNC_o <= 1'b1;
      DE_o    <= 1'b0;
    end else begin
      R_o     <= r_next;
      G_o     <= g_next;
      B_o     <= b_next;
      HSYNC_o <= tail_hs;
      VSYNC_o <= tail_vs;
      DE_o    <= tail_de;
    end
  end

endmodule

// File: tb/tb_osd_video_mixer.sv
// Directed bench for osd_video_mixer: coordinates, latency, overlay modes, blend latch, reset.
module tb_osd_video_mixer;

  logic       vclk = 1'b0;
  logic       rst_n = 1'b1;
  logic       clk_run = 1'b0;
  logic [7:0] R_i = '0, G_i = '0, B_i = '0;
  logic       HSYNC_i = 1'b1, VSYNC_i = 1'b1, DE_i = 1'b0;
  logic       blend_en = 1'b0, osd_enable = 1'b0, osd_color = 1'b0;
  logic [10:0] xpos, ypos;
  logic [7:0] R_o, G_o, B_o;
  logic       HSYNC_o, VSYNC_o, DE_o;

  int n_total = 0;
  int n_pass  = 0;

  always #5 vclk = clk_run ? ~vclk : 1'b0;

  osd_video_mixer #(.OSD_LATENCY(6), .COLOR_W(8)) dut (
    .vclk(vclk), .rst_n(rst_n),
    .R_i(R_i), .G_i(G_i), .B_i(B_i),
    .HSYNC_i(HSYNC_i), .VSYNC_i(VSYNC_i), .DE_i(DE_i),
    .blend_en(blend_en), .osd_enable(osd_enable), .osd_color(osd_color),
    .xpos(xpos), .ypos(ypos),
    .R_o(R_o), .G_o(G_o), .B_o(B_o),
    .HSYNC_o(HSYNC_o), .VSYNC_o(VSYNC_o), .DE_o(DE_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge vclk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  initial begin
    // Asynchronous reset with the clock stopped
    #2 rst_n = 1'b0;
    #1;
    check("rst_R", 32'(R_o), 'h0);
    check("rst_G", 32'(G_o), 'h0);
    check("rst_B", 32'(B_o), 'h0);
    check("rst_DE", 32'(DE_o), 'h0);
    check("rst_HS", 32'(HSYNC_o), 'h1);
    check("rst_VS", 32'(VSYNC_o), 'h1);
    check("rst_xpos", 32'(xpos), 'h0);
    check("rst_ypos", 32'(ypos), 'h0);
    R_i = 8'hAA; DE_i = 1'b1; HSYNC_i = 1'b0; VSYNC_i = 1'b0; osd_enable = 1'b1;
    #4;
    check("rst_toggle_R", 32'(R_o), 'h0);
    check("rst_toggle_HS", 32'(HSYNC_o), 'h1);
    clk_run = 1'b1;
    ticks(2);
    check("rst_clk_DE", 32'(DE_o), 'h0);
    check("rst_clk_xpos", 32'(xpos), 'h0);
    R_i = 8'h00; DE_i = 1'b0; HSYNC_i = 1'b1; VSYNC_i = 1'b1; osd_enable = 1'b0;
    rst_n = 1'b1;
    ticks(3);

    // Coordinates: vsync then three 640-pixel lines
    VSYNC_i = 1'b0; tick(); VSYNC_i = 1'b1;
    check("ypos_vsync", 32'(ypos), 'h0);
    for (int line = 0; line < 3; line++) begin
      ticks(4);
      for (int i = 0; i < 640; i++) begin
        DE_i = 1'b1;
        tick();
        if (i == 0 || i == 1 || i == 320 || i == 639)
          check($sformatf("xpos_l%0d_p%0d", line, i), 32'(xpos), 32'(i));
        if (i == 0) check($sformatf("ypos_l%0d", line), 32'(ypos), 32'(line));
      end
      DE_i = 1'b0;
      tick();
      check($sformatf("ypos_after_l%0d", line), 32'(ypos), 32'(line + 1));
    end
    ticks(4);
    for (int i = 0; i < 2100; i++) begin
      DE_i = 1'b1;
      tick();
      if (i == 2046 || i == 2047 || i == 2099)
        check($sformatf("xpos_long_p%0d", i), 32'(xpos), (i > 2047) ? 32'd2047 : 32'(i));
    end
    // End of line coinciding with vsync assertion: vsync wins
    DE_i = 1'b0; VSYNC_i = 1'b0;
    tick();
    VSYNC_i = 1'b1;
    check("ypos_vsync_priority", 32'(ypos), 'h0);
    check("xpos_hold", 32'(xpos), 'd2047);

    // Latency of pixel, DE and hsync
    ticks(10);
    R_i = 8'h12; DE_i = 1'b1; HSYNC_i = 1'b0;
    tick();
    R_i = 8'h00; DE_i = 1'b0; HSYNC_i = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 6) begin
        check("lat6_DE", 32'(DE_o), 'h0);
        check("lat6_HS", 32'(HSYNC_o), 'h1);
      end
      if (k == 7) begin
        check("lat7_DE", 32'(DE_o), 'h1);
        check("lat7_R", 32'(R_o), 'h12);
        check("lat7_HS", 32'(HSYNC_o), 'h0);
      end
      if (k == 8) check("lat8_DE", 32'(DE_o), 'h0);
    end
    VSYNC_i = 1'b0; tick(); VSYNC_i = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k == 6) check("lat6_VS", 32'(VSYNC_o), 'h1);
      if (k == 7) check("lat7_VS", 32'(VSYNC_o), 'h0);
    end

    // Overlay modes with blend latch cleared
    R_i = 8'hC8; G_i = 8'h40; B_i = 8'h03; DE_i = 1'b1;
    ticks(9);
    check("pass_R", 32'(R_o), 'hC8);
    check("pass_DE", 32'(DE_o), 'h1);
    osd_enable = 1'b1; osd_color = 1'b1;
    tick();
    check("glyph_R", 32'(R_o), 'hFF);
    check("glyph_G", 32'(G_o), 'hFF);
    check("glyph_B", 32'(B_o), 'hFF);
    osd_color = 1'b0;
    tick();
    check("bg_opaque_R", 32'(R_o), 'h00);
    check("bg_opaque_G", 32'(G_o), 'h00);
    blend_en = 1'b1;
    ticks(3);
    check("bg_midframe_R", 32'(R_o), 'h00);

    // Next frame picks up blend_en
    DE_i = 1'b0;
    ticks(3);
    VSYNC_i = 1'b0; tick(); VSYNC_i = 1'b1;
    DE_i = 1'b1;
    ticks(9);
    check("blend_R", 32'(R_o), 'h32);
    check("blend_G", 32'(G_o), 'h10);
    check("blend_B", 32'(B_o), 'h00);
    check("blend_DE", 32'(DE_o), 'h1);
    blend_en = 1'b0;
    ticks(2);
    check("blend_held_R", 32'(R_o), 'h32);

    // OSD during blanking is ignored
    DE_i = 1'b0; R_i = 8'h55; G_i = 8'h55; B_i = 8'h55;
    ticks(9);
    check("blank_bg_R", 32'(R_o), 'h55);
    check("blank_DE", 32'(DE_o), 'h0);
    osd_color = 1'b1;
    tick();
    check("blank_glyph_R", 32'(R_o), 'h55);
    check("blank_ypos", 32'(ypos), 'h1);

    // Reset pulse mid-line
    osd_enable = 1'b0; osd_color = 1'b0; R_i = 8'h10; DE_i = 1'b1;
    ticks(5);
    check("pre_rst_xpos", 32'(xpos), 'h4);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_R", 32'(R_o), 'h0);
    check("midrst_DE", 32'(DE_o), 'h0);
    check("midrst_HS", 32'(HSYNC_o), 'h1);
    check("midrst_xpos", 32'(xpos), 'h0);
    check("midrst_ypos", 32'(ypos), 'h0);
    #1 rst_n = 1'b1;
    DE_i = 1'b0;
    ticks(2);
    check("post_rst_xpos_idle", 32'(xpos), 'h0);
    DE_i = 1'b1;
    tick();
    check("post_rst_xpos0", 32'(xpos), 'h0);
    tick();
    check("post_rst_xpos1", 32'(xpos), 'h1);
    check("post_rst_ypos", 32'(ypos), 'h0);
    DE_i = 1'b0;
    tick();
    check("post_rst_ypos1", 32'(ypos), 'h1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
